regfile_wb_arbiter: RTL

Write-port arbiter and scoreboard for the 32x32 register file. It shares the file's single write port between the single-cycle core writeback path and a long-latency unit (multiply/divide or load) that returns results out of band. It tracks which destination registers have a long-latency result in flight, so the core can detect RAW/WAW hazards. It sits directly in front of the register file's regWrite/writeReg/writeData inputs.

---
 rtl/regfile_wb_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between the
// single-cycle core writeback path and a long-latency unit whose results come
// back out of band. A small FIFO buffers the long-latency results. A busy
// scoreboard marks destinations that have a result in flight, for hazard
// detection in decode.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   core_wen/waddr/wdata        core writeback request
//   issue_valid, issue_rd       long-latency op issued; marks rd busy
//   lu_valid/ready/waddr/wdata  long-latency result handshake
//   rs1, rs2, rd, hazard        decode hazard query against the busy bits
//   stall_req                   core must not write back this cycle
//   regWrite/writeReg/writeData register file write port
//   proto_err                   sticky protocol-violation flag
module regfile_wb_arbiter #(
  parameter int unsigned NREGS        = 32,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_wen,
  input  logic [4:0]      core_waddr,
  input  logic [XLEN-1:0] core_wdata,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_waddr,
  input  logic [XLEN-1:0] lu_wdata,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  output logic            hazard,
  output logic            stall_req,
  output logic            regWrite,
  output logic [4:0]      writeReg,
  output logic [XLEN-1:0] writeData,
  output logic            proto_err
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FullCnt   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

  logic [4:0]      mem_addr_q [FIFO_DEPTH];
  logic [4:0]      mem_addr_d [FIFO_DEPTH];
  logic [XLEN-1:0] mem_data_q [FIFO_DEPTH];
  logic [XLEN-1:0] mem_data_d [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic            proto_err_q, proto_err_d;

  logic            core_eff, fifo_empty, fifo_full;
  logic            grant_fifo, grant_core, push, lu_accept;
  logic [4:0]      head_addr;
  logic [XLEN-1:0] head_data;

  always_comb begin
    core_eff   = core_wen && (core_waddr != 5'd0);
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == FullCnt);
    stall_req  = (starve_q == StarveMax);
    head_addr  = mem_addr_q[rd_ptr_q];
    head_data  = mem_data_q[rd_ptr_q];
    // Under stall the head drains unconditionally and any core write is lost.
    grant_fifo = !rst && !fifo_empty && (stall_req || !core_eff);
    grant_core = !rst && core_eff && !stall_req;
    lu_ready   = !rst && !fifo_full;
    lu_accept  = lu_valid && lu_ready;
    push       = lu_accept && (lu_waddr != 5'd0);
    hazard     = busy_q[rs1] | busy_q[rs2] | busy_q[rd];
    proto_err  = proto_err_q;
  end

  always_comb begin
    regWrite  = 1'b0;
    writeReg  = 5'd0;
    writeData = '0;
    if (grant_core) begin
      regWrite  = 1'b1;
      writeReg  = core_waddr;
      writeData = core_wdata;
    end else if (grant_fifo) begin
      regWrite  = 1'b1;
      writeReg  = head_addr;
      writeData = head_data;
    end
  end

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    if (push) begin
      mem_addr_d[wr_ptr_q] = lu_waddr;
      mem_data_d[wr_ptr_q] = lu_wdata;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (grant_fifo) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, grant_fifo})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (fifo_empty || grant_fifo) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end

    // Clear first so a same-cycle issue to the drained register stays busy.
    busy_d = busy_q;
    if (grant_fifo) begin
      busy_d[head_addr] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end

    proto_err_d = proto_err_q;
    if ((issue_valid && busy_q[issue_rd]) ||
        (core_eff && busy_q[core_waddr]) ||
        (push && !busy_q[lu_waddr]) ||
        (core_eff && stall_req)) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q  <= '{default: '0};
      mem_data_q  <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
      busy_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      busy_q      <= busy_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule
